// File: rtl/nec_ir_pkg.sv
// Shared constants, FSM encoding and the frame check helper for the NEC IR receiver.
package nec_ir_pkg;

    localparam int CNT_W          = 18;
    localparam int NEC_FRAME_BITS = 32;

    localparam int unsigned CLK_HZ_DEF = 12_000_000;
    // Envelope hold is 50 us, i.e. one twenty-thousandth of a second.
    localparam int unsigned GAP_DIV    = 20_000;

    localparam logic [CNT_W-1:0] LMARK_MIN_DEF = 18'd96000;
    localparam logic [CNT_W-1:0] LMARK_MAX_DEF = 18'd120000;
    localparam logic [CNT_W-1:0] LSPC_MIN_DEF  = 18'd48000;
    localparam logic [CNT_W-1:0] LSPC_MAX_DEF  = 18'd60000;
    localparam logic [CNT_W-1:0] RSPC_MIN_DEF  = 18'd24000;
    localparam logic [CNT_W-1:0] RSPC_MAX_DEF  = 18'd30000;
    localparam logic [CNT_W-1:0] BMARK_MIN_DEF = 18'd4800;
    localparam logic [CNT_W-1:0] BMARK_MAX_DEF = 18'd8400;
    localparam logic [CNT_W-1:0] S0_MIN_DEF    = 18'd4800;
    localparam logic [CNT_W-1:0] S0_MAX_DEF    = 18'd8400;
    localparam logic [CNT_W-1:0] S1_MIN_DEF    = 18'd16800;
    localparam logic [CNT_W-1:0] S1_MAX_DEF    = 18'd22800;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LEAD_MARK  = 3'd1,
        LEAD_SPACE = 3'd2,
        BIT_MARK   = 3'd3,
        BIT_SPACE  = 3'd4,
        STOP_MARK  = 3'd5,
        REP_STOP   = 3'd6
    } state_t;

    function automatic logic nec_check(input logic [NEC_FRAME_BITS-1:0] w);
        return (w[15:8] == ~w[7:0]) && (w[31:24] == ~w[23:16]);
    endfunction

endpackage

// File: rtl/ir_envelope.sv
// Synchronizes the raw IR pin and turns the 38 kHz carrier bursts into a clean
// envelope with one-cycle rise/fall pulses aligned to the envelope change.
module ir_envelope #(
    parameter bit          RX_ACTIVE = 1'b1,
    parameter int unsigned GAP_CYC   = 600
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rxd,
    output logic env,
    output logic rise,
    output logic fall
);

    localparam int GW = $clog2(GAP_CYC + 1);

    logic          sync1;
    logic          sync2;
    logic          active;
    logic          env_n;
    logic [GW-1:0] gap;
    logic [GW-1:0] gap_n;

    assign active = (sync2 == RX_ACTIVE);

    // Carrier-off halves are bridged until the hold counter has run its full length.
    always_comb begin
        env_n = env;
        gap_n = gap;
        if (active) begin
            env_n = 1'b1;
            gap_n = '0;
        end else if (env) begin
            if (gap == GW'(GAP_CYC)) begin
                env_n = 1'b0;
                gap_n = '0;
            end else begin
                gap_n = gap + GW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= ~RX_ACTIVE;
            sync2 <= ~RX_ACTIVE;
            env   <= 1'b0;
            gap   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= rxd;
            sync2 <= sync1;
            env   <= env_n;
            gap   <= gap_n;
            rise  <= env_n & ~env;
            fall  <= ~env_n & env;
        end
    end

endmodule

// File: rtl/nec_ir_receiver.sv
// NEC IR frame decoder: measures envelope mark/space durations and walks the
// leader, 32 data bits and stop mark, publishing the word with status strobes.
module nec_ir_receiver
    import nec_ir_pkg::*;
#(
    parameter int unsigned      CLK_HZ    = CLK_HZ_DEF,
    parameter bit               RX_ACTIVE = 1'b1,
    parameter int unsigned      GAP_CYC   = CLK_HZ / GAP_DIV,
    parameter logic [CNT_W-1:0] LMARK_MIN = LMARK_MIN_DEF,
    parameter logic [CNT_W-1:0] LMARK_MAX = LMARK_MAX_DEF,
    parameter logic [CNT_W-1:0] LSPC_MIN  = LSPC_MIN_DEF,
    parameter logic [CNT_W-1:0] LSPC_MAX  = LSPC_MAX_DEF,
    parameter logic [CNT_W-1:0] RSPC_MIN  = RSPC_MIN_DEF,
    parameter logic [CNT_W-1:0] RSPC_MAX  = RSPC_MAX_DEF,
    parameter logic [CNT_W-1:0] BMARK_MIN = BMARK_MIN_DEF,
    parameter logic [CNT_W-1:0] BMARK_MAX = BMARK_MAX_DEF,
    parameter logic [CNT_W-1:0] S0_MIN    = S0_MIN_DEF,
    parameter logic [CNT_W-1:0] S0_MAX    = S0_MAX_DEF,
    parameter logic [CNT_W-1:0] S1_MIN    = S1_MIN_DEF,
    parameter logic [CNT_W-1:0] S1_MAX    = S1_MAX_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      RXD,
    output logic [NEC_FRAME_BITS-1:0] rx_data,
    output logic                      rx_valid,
    output logic                      rx_repeat,
    output logic                      rx_err,
    output logic                      rx_check_ok,
    output logic                      busy
);

    logic                      env;
    logic                      rise;
    logic                      fall;
    logic                      rise_d;
    logic                      have_frame;
    logic                      timeout;
    state_t                    state;
    logic [CNT_W-1:0]          dur;
    logic [CNT_W-1:0]          phase_max;
    logic [4:0]                bit_idx;
    logic [NEC_FRAME_BITS-1:0] shadow;

    ir_envelope #(
        .RX_ACTIVE (RX_ACTIVE),
        .GAP_CYC   (GAP_CYC)
    ) u_env (
        .clk   (clk),
        .rst_n (rst_n),
        .rxd   (RXD),
        .env   (env),
        .rise  (rise),
        .fall  (fall)
    );

    function automatic logic in_win(input logic [CNT_W-1:0] d, lo, hi);
        return (d >= lo) && (d <= hi);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dur <= '0;
        end else if (rise || fall) begin
            dur <= '0;
        end else if (dur != {CNT_W{1'b1}}) begin
            dur <= dur + CNT_W'(1);
        end
    end

    always_comb begin
        case (state)
            LEAD_MARK:  phase_max = LMARK_MAX;
            LEAD_SPACE: phase_max = LSPC_MAX;
            BIT_SPACE:  phase_max = S1_MAX;
            default:    phase_max = BMARK_MAX;
        endcase
        timeout = (state != IDLE) && (dur > phase_max);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_repeat   <= 1'b0;
            rx_err      <= 1'b0;
            rx_check_ok <= 1'b0;
            have_frame  <= 1'b0;
            rise_d      <= 1'b0;
            bit_idx     <= '0;
            shadow      <= '0;
        end else begin
            rx_valid  <= 1'b0;
            rx_repeat <= 1'b0;
            rx_err    <= 1'b0;
            rise_d    <= rise;
            if (timeout) begin
                rx_err <= 1'b1;
                state  <= IDLE;
            end else begin
                case (state)
                    // rise_d catches a leader that started in the cycle an error was flagged.
                    IDLE: if (rise || (rise_d && env)) state <= LEAD_MARK;
                    LEAD_MARK: if (fall) state <= (dur >= LMARK_MIN) ? LEAD_SPACE : IDLE;
                    LEAD_SPACE: if (rise) begin
                        if (in_win(dur, LSPC_MIN, LSPC_MAX)) begin
                            state   <= BIT_MARK;
                            bit_idx <= '0;
                        end else if (in_win(dur, RSPC_MIN, RSPC_MAX)) begin
                            state <= REP_STOP;
                        end else begin
                            rx_err <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                    BIT_MARK: if (fall) begin
                        if (in_win(dur, BMARK_MIN, BMARK_MAX)) begin
                            state <= BIT_SPACE;
                        end else begin
                            rx_err <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                    BIT_SPACE: if (rise) begin
                        if (in_win(dur, S0_MIN, S0_MAX) || in_win(dur, S1_MIN, S1_MAX)) begin
                            shadow  <= {in_win(dur, S1_MIN, S1_MAX), shadow[NEC_FRAME_BITS-1:1]};
                            bit_idx <= bit_idx + 5'd1;
                            state   <= (bit_idx == 5'(NEC_FRAME_BITS - 1)) ? STOP_MARK : BIT_MARK;
                        end else begin
                            rx_err <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                    STOP_MARK: if (fall) begin
                        if (in_win(dur, BMARK_MIN, BMARK_MAX)) begin
                            rx_data     <= shadow;
                            rx_check_ok <= nec_check(shadow);
                            rx_valid    <= 1'b1;
                            have_frame  <= 1'b1;
                        end else begin
                            rx_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    REP_STOP: if (fall) begin
                        if (in_win(dur, BMARK_MIN, BMARK_MAX) && have_frame) begin
                            rx_repeat <= 1'b1;
                        end else begin
                            rx_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nec_ir_receiver.sv
// Drives carrier-modulated NEC traffic (timing scaled down 200x) into the receiver
// and compares every status strobe against a frame-level model of the protocol.
module tb_nec_ir_receiver;

    localparam int W    = 35;
    localparam int GAP  = 3;
    localparam int T_LM = 540;   // 9 ms leader mark
    localparam int T_LS = 270;   // 4.5 ms leader space
    localparam int T_RS = 135;   // 2.25 ms repeat space
    localparam int T_BM = 34;    // 560 us bit / stop mark
    localparam int T_S0 = 34;
    localparam int T_S1 = 101;
    localparam int S1_MAX_TB = 114;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rxd;
    logic [31:0] rx_data;
    logic        rx_valid, rx_repeat, rx_err, rx_check_ok, busy;

    nec_ir_receiver #(
        .CLK_HZ    (60000),
        .RX_ACTIVE (1'b1),
        .GAP_CYC   (GAP),
        .LMARK_MIN (18'd480), .LMARK_MAX (18'd600),
        .LSPC_MIN  (18'd240), .LSPC_MAX  (18'd300),
        .RSPC_MIN  (18'd120), .RSPC_MAX  (18'd150),
        .BMARK_MIN (18'd24),  .BMARK_MAX (18'd42),
        .S0_MIN    (18'd24),  .S0_MAX    (18'd42),
        .S1_MIN    (18'd84),  .S1_MAX    (18'd114)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RXD         (rxd),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_repeat   (rx_repeat),
        .rx_err      (rx_err),
        .rx_check_ok (rx_check_ok),
        .busy        (busy)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard: {kind, check_ok, data}, kind 1=valid 2=repeat 3=err ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];
    bit           have = 1'b0;
    logic [31:0]  last_d = '0;
    logic         last_ok = 1'b0;

    int fall_cyc, lead_start, rise_cyc;
    int busy_rise = 0;
    int ev_cyc = 0;
    logic busy_q = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_q = 1'b0;
        end else begin
            if (busy && !busy_q) busy_rise = cyc;
            busy_q = busy;
            if (rx_valid || rx_repeat || rx_err) begin
                check("strobe_onehot", 64'(int'(rx_valid) + int'(rx_repeat) + int'(rx_err)), 64'd1);
                obs_q.push_back({rx_valid ? 2'd1 : (rx_repeat ? 2'd2 : 2'd3), rx_check_ok, rx_data});
                ev_cyc = cyc;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic model_ok(input logic [31:0] d);
        int b0, b1, b2, b3;
        b0 = int'(d & 32'hFF);
        b1 = int'((d >> 8) & 32'hFF);
        b2 = int'((d >> 16) & 32'hFF);
        b3 = int'((d >> 24) & 32'hFF);
        return (b1 == 255 - b0) && (b3 == 255 - b2);
    endfunction

    task automatic exp_frame(input logic [31:0] d);
        have    = 1'b1;
        last_d  = d;
        last_ok = model_ok(d);
        exp_q.push_back({2'd1, last_ok, last_d});
    endtask

    task automatic exp_repeat();
        exp_q.push_back({have ? 2'd2 : 2'd3, last_ok, last_d});
    endtask

    task automatic exp_err();
        exp_q.push_back({2'd3, last_ok, last_d});
    endtask

    // ---------------- drivers ----------------
    task automatic mark(input int n);
        for (int i = 0; i < n; i++) begin
            rxd = (i % 2 == 0);
            if (i % 2 == 1) fall_cyc = cyc;
            @(negedge clk);
        end
        if (rxd) fall_cyc = cyc;
        rxd = 1'b0;
    endtask

    task automatic space(input int n);
        rxd = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    function automatic int jit(input bit on);
        return on ? int'($urandom_range(0, 4)) - 2 : 0;
    endfunction

    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_data", 64'(rx_data), 64'd0);
        check("rst_async_strobes", 64'({rx_valid, rx_repeat, rx_err, rx_check_ok, busy}), 64'd0);
        repeat (3) @(negedge clk);
        rxd   = 1'b0;
        rst_n = 1'b1;
        have    = 1'b0;
        last_d  = '0;
        last_ok = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] d, input int cut_after, input int rst_at, input bit j);
        lead_start = cyc;
        mark(T_LM + jit(j));
        space(T_LS + jit(j));
        for (int i = 0; i < 32; i++) begin
            if (i == rst_at) begin
                mid_reset();
                return;
            end
            mark(T_BM + jit(j));
            if (i == cut_after) return;
            space((d[i] ? T_S1 : T_S0) + jit(j));
        end
        mark(T_BM);
    endtask

    task automatic send_repeat();
        mark(T_LM);
        space(T_RS);
        mark(T_BM);
    endtask

    task automatic drain(input string tag);
        space(250);
        check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_event"}, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
        obs_q.delete();
        exp_q.delete();
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] d;
        rst_n = 1'b0;
        rxd   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_data", 64'(rx_data), 64'd0);
        check("reset_valid", 64'(rx_valid), 64'd0);
        check("reset_repeat", 64'(rx_repeat), 64'd0);
        check("reset_err", 64'(rx_err), 64'd0);
        check("reset_check_ok", 64'(rx_check_ok), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send_repeat(); exp_repeat(); drain("rep_no_frame");

        send_frame(32'hFF00FB04, -1, -1, 1'b0); exp_frame(32'hFF00FB04);
        drain("frame_fb04");
        check("valid_latency", 64'(ev_cyc - fall_cyc), 64'(GAP + 4));
        check("busy_latency", 64'(busy_rise - lead_start), 64'd4);

        space(2400);
        send_repeat(); exp_repeat(); drain("repeat_40ms");

        send_frame(32'hFF00FB05, -1, -1, 1'b0); exp_frame(32'hFF00FB05);
        drain("frame_fb05");

        mark(420); drain("short_leader");

        mark(T_LM); space(210);
        rise_cyc = cyc;
        mark(T_BM); exp_err();
        drain("bad_space");
        check("err_at_rise", 64'(ev_cyc - rise_cyc), 64'd4);

        send_frame(32'h12345678, 15, -1, 1'b0); exp_err();
        drain("lost_carrier");
        check("lost_carrier_time",
              64'((ev_cyc - fall_cyc >= S1_MAX_TB) && (ev_cyc - fall_cyc <= S1_MAX_TB + GAP + 10)), 64'd1);

        send_frame(32'hA5A5C33C, -1, 10, 1'b0);
        drain("reset_mid_frame");

        send_frame(32'h00FF00FF, -1, -1, 1'b0); exp_frame(32'h00FF00FF);
        drain("frame_after_reset");

        for (int k = 0; k < 5; k++) begin
            d = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                d[15:8]  = ~d[7:0];
                d[31:24] = ~d[23:16];
            end
            send_frame(d, -1, -1, 1'b1); exp_frame(d);
            drain("rand_frame");
            if ($urandom_range(0, 1) == 1) begin
                send_repeat(); exp_repeat(); drain("rand_repeat");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
